// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and byte/half/word sequencer for a single-port data memory.
// Optional round-robin arbitration when DMEM_ARB_RR_EN is defined; fixed priority (r0 wins) otherwise.
module dmem_arbiter #(
  parameter int MEM_WORDS = 32768,
  parameter int IDX_W     = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [1:0]       r0_size,
  input  logic             r0_unsigned,
  input  logic [31:0]      r0_addr,
  input  logic [31:0]      r0_wdata,
  output logic             r0_gnt,
  output logic             r0_rvalid,
  output logic [31:0]      r0_rdata,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [1:0]       r1_size,
  input  logic             r1_unsigned,
  input  logic [31:0]      r1_addr,
  input  logic [31:0]      r1_wdata,
  output logic             r1_gnt,
  output logic             r1_rvalid,
  output logic [31:0]      r1_rdata,
  output logic             r1_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t st;
  logic w, we, u, ill, win, uns_q, ld;
  logic [1:0] s, sz_q, lane;
  logic [3:0] be;
  logic [31:0] a, wd, wrep, sh, ext;
`ifdef DMEM_ARB_RR_EN
  logic last;
  assign w = (r0_req & r1_req) ? ~last : r1_req;
`else
  assign w = ~r0_req;
`endif
  always_comb begin
    we   = w ? r1_we : r0_we;
    s    = w ? r1_size : r0_size;
    u    = w ? r1_unsigned : r0_unsigned;
    a    = w ? r1_addr : r0_addr;
    wd   = w ? r1_wdata : r0_wdata;
    ill  = (s == 2'b11) | ((s == 2'b01) & a[0]) | ((s == 2'b10) & (|a[1:0]))
         | ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
    be   = (s == 2'b00) ? 4'b0001 << a[1:0] : (s == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = (s == 2'b00) ? {4{wd[7:0]}} : (s == 2'b01) ? {2{wd[15:0]}} : wd;
    sh   = mem_rdata >> {lane, 3'b000};
    ext  = (sz_q == 2'b00) ? {{24{~uns_q & sh[7]}}, sh[7:0]}
         : (sz_q == 2'b01) ? {{16{~uns_q & sh[15]}}, sh[15:0]} : mem_rdata;
  end
  assign r0_rdata = r0_rvalid ? ext : '0;
  assign r1_rdata = r1_rvalid ? ext : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      {win, uns_q, ld, sz_q, lane} <= '0;
      {r0_gnt, r1_gnt, r0_err, r1_err, r0_rvalid, r1_rvalid} <= '0;
      {mem_en, mem_we, mem_be, mem_idx, mem_wdata} <= '0;
`ifdef DMEM_ARB_RR_EN
      last <= 1'b1;
`endif
    end else begin
      {r0_gnt, r1_gnt, r0_err, r1_err, r0_rvalid, r1_rvalid} <= '0;
      {mem_en, mem_we, mem_be, mem_idx, mem_wdata} <= '0;
      case (st)
        IDLE: if (r0_req | r1_req) begin
          st        <= ISSUE;
          win       <= w;
          sz_q      <= s;
          uns_q     <= u;
          lane      <= a[1:0];
          ld        <= ~we & ~ill;
          r0_gnt    <= ~w;
          r1_gnt    <= w;
          r0_err    <= ~w & ill;
          r1_err    <= w & ill;
          mem_en    <= ~ill;
          mem_we    <= we & ~ill;
          mem_be    <= ill ? 4'b0000 : be;
          mem_idx   <= ill ? '0 : a[IDX_W+1:2];
          mem_wdata <= ill ? '0 : wrep;
`ifdef DMEM_ARB_RR_EN
          last      <= w;
`endif
        end
        ISSUE: begin
          st        <= ld ? RESP : IDLE;
          r0_rvalid <= ld & ~win;
          r1_rvalid <= ld & win;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic r0_req, r0_we, r0_unsigned, r1_req, r1_we, r1_unsigned;
  logic [1:0] r0_size, r1_size;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic mem_en, mem_we;
  logic [3:0] mem_be;
  logic [14:0] mem_idx;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:32767];
  int checks = 0;
  int errors = 0;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_unsigned(r0_unsigned),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_unsigned(r1_unsigned),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
    end else if (mem_en) mem_rdata <= mem[mem_idx];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
    if (k == 0) begin
      r0_req = 1'b1; r0_we = we; r0_size = sz; r0_unsigned = u; r0_addr = a; r0_wdata = wd;
    end else begin
      r1_req = 1'b1; r1_we = we; r1_size = sz; r1_unsigned = u; r1_addr = a; r1_wdata = wd;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    r0_req = 0; r0_we = 0; r0_size = 0; r0_unsigned = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_size = 0; r1_unsigned = 0; r1_addr = 0; r1_wdata = 0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({r0_gnt, r1_gnt, r0_err, r1_err, r0_rvalid, r1_rvalid} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {r0_gnt, r1_gnt, r0_err, r1_err, r0_rvalid, r1_rvalid}); end
    checks++; if ({mem_en, mem_we, mem_be, mem_idx, mem_wdata} !== 53'b0) begin errors++; $display("FAIL reset_mem got en=%b we=%b be=%b idx=%h wd=%h exp all 0", mem_en, mem_we, mem_be, mem_idx, mem_wdata); end
    checks++; if ({r0_rdata, r1_rdata} !== 64'b0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0", r0_rdata, r1_rdata); end
  endtask

  task automatic test_byte();
    req(0, 1'b1, 2'b00, 1'b0, 32'h105, 32'hAB);
    tick();
    r0_req = 1'b0;
    checks++; if ({r0_gnt, r1_gnt, r0_err, mem_en, mem_we} !== 5'b10011) begin errors++; $display("FAIL sb_ctrl got gnt0/gnt1/err/en/we=%b exp 10011", {r0_gnt, r1_gnt, r0_err, mem_en, mem_we}); end
    checks++; if (mem_be !== 4'b0010) begin errors++; $display("FAIL sb_be got %b exp 0010", mem_be); end
    checks++; if (mem_idx !== 15'h41) begin errors++; $display("FAIL sb_idx got %h exp 41", mem_idx); end
    checks++; if (mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h exp ABABABAB", mem_wdata); end
    tick();
    checks++; if ({r0_gnt, mem_en} !== 2'b00) begin errors++; $display("FAIL sb_pulse got gnt/en=%b exp 00", {r0_gnt, mem_en}); end
    req(0, 1'b0, 2'b00, 1'b0, 32'h105, 32'h0);
    tick();
    r0_req = 1'b0;
    checks++; if ({r0_gnt, mem_en, mem_we, r0_rvalid} !== 4'b1100) begin errors++; $display("FAIL lb_issue got gnt/en/we/rv=%b exp 1100", {r0_gnt, mem_en, mem_we, r0_rvalid}); end
    tick();
    checks++; if ({r0_rvalid, r1_rvalid} !== 2'b10) begin errors++; $display("FAIL lb_rvalid got %b exp 10", {r0_rvalid, r1_rvalid}); end
    checks++; if (r0_rdata !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_rdata got %h exp FFFFFFAB", r0_rdata); end
    tick();
    checks++; if ({r0_rvalid, r0_rdata} !== 33'b0) begin errors++; $display("FAIL lb_after got rv=%b rdata=%h exp 0", r0_rvalid, r0_rdata); end
    req(0, 1'b0, 2'b00, 1'b1, 32'h105, 32'h0);
    tick(); r0_req = 1'b0; tick();
    checks++; if (r0_rdata !== 32'h000000AB) begin errors++; $display("FAIL lbu_rdata got %h exp 000000AB", r0_rdata); end
    tick();
  endtask

  task automatic test_half();
    req(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h8001);
    tick(); r0_req = 1'b0;
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", mem_be); end
    checks++; if (mem_wdata !== 32'h80018001) begin errors++; $display("FAIL sh_wdata got %h exp 80018001", mem_wdata); end
    tick();
    req(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    tick(); r0_req = 1'b0; tick();
    checks++; if (r0_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", r0_rdata); end
    tick();
    req(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    tick(); r0_req = 1'b0; tick();
    checks++; if (r0_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata got %h exp FFFF8001", r0_rdata); end
    tick();
  endtask

  task automatic test_errors();
    req(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    tick(); r0_req = 1'b0;
    checks++; if ({r0_gnt, r0_err, mem_en, r1_err} !== 4'b1100) begin errors++; $display("FAIL lw_misalign got gnt/err/en/err1=%b exp 1100", {r0_gnt, r0_err, mem_en, r1_err}); end
    tick();
    checks++; if ({r0_err, r0_rvalid} !== 2'b00) begin errors++; $display("FAIL err_pulse got err/rv=%b exp 00", {r0_err, r0_rvalid}); end
    req(1, 1'b1, 2'b10, 1'b0, 32'h20000, 32'h12345678);
    tick(); r1_req = 1'b0;
    checks++; if ({r1_gnt, r1_err, mem_en, mem_we, r0_gnt} !== 5'b11000) begin errors++; $display("FAIL sw_range got gnt/err/en/we/gnt0=%b exp 11000", {r1_gnt, r1_err, mem_en, mem_we, r0_gnt}); end
    tick();
    req(0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    tick(); r0_req = 1'b0;
    checks++; if ({r0_err, mem_en} !== 2'b10) begin errors++; $display("FAIL size11 got err/en=%b exp 10", {r0_err, mem_en}); end
    tick();
    req(0, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    tick(); r0_req = 1'b0;
    checks++; if ({r0_err, mem_en} !== 2'b10) begin errors++; $display("FAIL half_odd got err/en=%b exp 10", {r0_err, mem_en}); end
    tick();
    req(0, 1'b0, 2'b10, 1'b0, 32'h1FFFC, 32'h0);
    tick(); r0_req = 1'b0;
    checks++; if ({r0_err, mem_en, mem_idx} !== {2'b01, 15'h7FFF}) begin errors++; $display("FAIL last_word got err/en=%b idx=%h exp 01 7FFF", {r0_err, mem_en}, mem_idx); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    int n = 0;
    req(1, 1'b1, 2'b10, 1'b0, 32'h0, data[0]);
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++; if (r1_gnt !== (t % 2 == 1)) begin errors++; $display("FAIL b2b_gnt t=%0d got %b exp %b", t, r1_gnt, (t % 2 == 1)); end
      if (r1_gnt) begin
        n++;
        if (n < 4) req(1, 1'b1, 2'b10, 1'b0, 32'(n * 4), data[n]);
        else r1_req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      req(1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      tick(); r1_req = 1'b0; tick();
      checks++; if ({r1_rvalid, r1_rdata, r0_rvalid} !== {1'b1, data[i], 1'b0}) begin errors++; $display("FAIL b2b_read%0d got rv=%b rdata=%h exp 1 %h", i, r1_rvalid, r1_rdata, data[i]); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    req(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick(); r0_req = 1'b0; tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({r0_rvalid, r0_rdata, r0_gnt, mem_en} !== 35'b0) begin errors++; $display("FAIL arst_now got rv=%b rdata=%h gnt=%b en=%b exp 0", r0_rvalid, r0_rdata, r0_gnt, mem_en); end
    tick();
    checks++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin errors++; $display("FAIL arst_hold got %b exp 00", {r0_rvalid, r1_rvalid}); end
    rst_n = 1'b1;
    req(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick(); r0_req = 1'b0;
    checks++; if ({r0_gnt, mem_en} !== 2'b11) begin errors++; $display("FAIL arst_regrant got gnt/en=%b exp 11", {r0_gnt, mem_en}); end
    tick();
    checks++; if ({r0_rvalid, r0_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL arst_read got rv=%b rdata=%h exp 1 DEADBEEF", r0_rvalid, r0_rdata); end
    tick();
  endtask

  task automatic test_contention();
    logic eg0, eg1, ev0, ev1;
    apply_reset();
    req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    req(1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    for (int t = 1; t <= 12; t++) begin
      tick();
      eg0 = (t % 3 == 1) && (!RR || (t / 3) % 2 == 0);
      eg1 = (t % 3 == 1) && RR && (t / 3) % 2 == 1;
      ev0 = (t % 3 == 2) && (!RR || (t / 3) % 2 == 0);
      ev1 = (t % 3 == 2) && RR && (t / 3) % 2 == 1;
      checks++; if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== {eg0, eg1, ev0, ev1}) begin errors++; $display("FAIL contend t=%0d got g0/g1/v0/v1=%b exp %b", t, {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, {eg0, eg1, ev0, ev1}); end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    mem_rdata = 32'h0;
    test_reset();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_async_reset();
    test_contention();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
